// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the set-associative instruction cache.
// master: fetch unit / memory controller environment; slave: the cache itself.
interface icache_assoc_if #(
    parameter int unsigned BLOCK_WORDS = 2
);
    localparam int unsigned BADDR_W = 30 - $clog2(BLOCK_WORDS);

    logic                       icache_REN;
    logic [31:0]                icache_addr;
    logic                       icache_halt;
    logic                       icache_hit;
    logic [31:0]                icache_load;
    logic                       imem_REN;
    logic [BADDR_W-1:0]         imem_block_addr;
    logic                       imem_hit;
    logic [32*BLOCK_WORDS-1:0]  imem_load;

    modport master (
        output icache_REN, icache_addr, icache_halt, imem_hit, imem_load,
        input  icache_hit, icache_load, imem_REN, imem_block_addr
    );

    modport slave (
        input  icache_REN, icache_addr, icache_halt, imem_hit, imem_load,
        output icache_hit, icache_load, imem_REN, imem_block_addr
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with tree pseudo-LRU replacement and a latched-address fill FSM.
// Optional next-line prefetch after demand fills: define ICACHE_NEXT_LINE_PREFETCH_EN.
module icache_assoc #(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned NUM_WAYS    = 2,
    parameter int unsigned BLOCK_WORDS = 2
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          DUT_error,
    icache_assoc_if.slave bus
);
    localparam int unsigned WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_BITS  = $clog2(NUM_SETS);
    localparam int unsigned OFF_BITS  = 2 + WORD_BITS;
    localparam int unsigned BADDR_W   = 30 - WORD_BITS;
    localparam int unsigned TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
    localparam int unsigned LVLS      = $clog2(NUM_WAYS);
    localparam int unsigned WAY_BITS  = (NUM_WAYS > 1) ? LVLS : 1;
    localparam int unsigned PLRU_W    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int unsigned BLK_W     = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FILL     = 2'd1,
        S_HALTED   = 2'd2
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        , S_PREFETCH = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [BADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic                 halt_q, halt_d;

    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [PLRU_W-1:0]    plru_q  [NUM_SETS];
    logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0]     data_q  [NUM_SETS][NUM_WAYS];

    // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 steers towards the right child.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int unsigned node;
        node = 1;
        for (int l = 0; l < int'(LVLS); l++) begin
            node = 2 * node + (bits[node-1] ? 1 : 0);
        end
        return WAY_BITS'(node - NUM_WAYS);
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_BITS-1:0] way);
        logic [PLRU_W-1:0] res;
        int unsigned       node;
        int unsigned       dir;
        res  = bits;
        node = 1;
        for (int l = 0; l < int'(LVLS); l++) begin
            dir           = (32'(way) >> (int'(LVLS) - 1 - l)) & 32'd1;
            res[node-1]   = (dir == 0);
            node          = 2 * node + dir;
        end
        return res;
    endfunction

    // Demand address decode and lookup
    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [WORD_BITS-1:0] req_word;
    logic [BADDR_W-1:0]   req_block;
    logic                 lookup_hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [BLK_W-1:0]     hit_block;

    assign req_idx   = bus.icache_addr[OFF_BITS +: IDX_BITS];
    assign req_tag   = bus.icache_addr[31 -: TAG_BITS];
    assign req_word  = bus.icache_addr[2 +: WORD_BITS];
    assign req_block = bus.icache_addr[31:OFF_BITS];

    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_BITS'(w);
            end
        end
    end

    assign hit_block = data_q[req_idx][hit_way];

    // Fill target: lowest invalid way wins over the PLRU choice
    logic [IDX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]  fill_tag;
    logic [WAY_BITS-1:0]  victim;

    assign fill_idx = fill_addr_q[IDX_BITS-1:0];
    assign fill_tag = fill_addr_q[BADDR_W-1 -: TAG_BITS];

    always_comb begin
        victim = plru_victim(plru_q[fill_idx]);
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx][w]) victim = WAY_BITS'(w);
        end
    end

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    logic [BADDR_W-1:0]   next_block;
    logic [IDX_BITS-1:0]  next_idx;
    logic                 next_resident;

    assign next_block = fill_addr_q + BADDR_W'(1);
    assign next_idx   = next_block[IDX_BITS-1:0];

    // block+1 always lands in a different set, so the concurrent fill write cannot affect this check
    always_comb begin
        next_resident = 1'b0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[next_idx][w] && tag_q[next_idx][w] == next_block[BADDR_W-1 -: TAG_BITS])
                next_resident = 1'b1;
        end
    end
`endif

    logic serving;
    logic req_valid;
    logic miss_c;
    logic hit_c;
    logic fill_c;
    logic imem_ren_c;
    logic err_c;
    logic [BADDR_W-1:0] block_addr_c;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    assign serving = (state_q == S_IDLE) || (state_q == S_PREFETCH);
`else
    assign serving = (state_q == S_IDLE);
`endif

    assign req_valid = bus.icache_REN && !bus.icache_halt;
    assign miss_c    = req_valid && !lookup_hit;
    assign hit_c     = !RST && req_valid && lookup_hit && serving;

    // Next-state and memory-side outputs
    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        halt_d       = halt_q;
        imem_ren_c   = 1'b0;
        block_addr_c = '0;
        err_c        = 1'b0;
        fill_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_c = bus.imem_hit;
                if (bus.icache_halt) begin
                    state_d = S_HALTED;
                end else if (miss_c) begin
                    imem_ren_c   = 1'b1;
                    block_addr_c = req_block;
                    fill_addr_d  = req_block;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                imem_ren_c   = 1'b1;
                block_addr_c = fill_addr_q;
                halt_d       = halt_q | bus.icache_halt;
                if (bus.imem_hit) begin
                    fill_c = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                    if (!next_resident) begin
                        fill_addr_d = next_block;
                        state_d     = S_PREFETCH;
                    end else
`endif
                    state_d = (halt_q || bus.icache_halt) ? S_HALTED : S_IDLE;
                end
            end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            S_PREFETCH: begin
                imem_ren_c   = 1'b1;
                block_addr_c = fill_addr_q;
                halt_d       = halt_q | bus.icache_halt;
                if (bus.imem_hit) begin
                    fill_c = 1'b1;
                    if (halt_q || bus.icache_halt) begin
                        state_d = S_HALTED;
                    end else if (miss_c && req_block != fill_addr_q) begin
                        fill_addr_d = req_block;
                        state_d     = S_FILL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_HALTED: begin
                err_c = bus.imem_hit;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (RST) begin
            imem_ren_c   = 1'b0;
            block_addr_c = '0;
            err_c        = 1'b0;
            fill_c       = 1'b0;
        end
    end

    assign bus.icache_hit      = hit_c;
    assign bus.icache_load     = hit_c ? hit_block[{req_word, 5'd0} +: 32] : 32'h0;
    assign bus.imem_REN        = imem_ren_c;
    assign bus.imem_block_addr = block_addr_c;
    assign DUT_error           = err_c;

    // Control state, valid bits and replacement state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            halt_q      <= 1'b0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            halt_q      <= halt_d;
            if (hit_c) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            end
            if (fill_c) begin
                valid_q[fill_idx][victim] <= 1'b1;
                plru_q[fill_idx]          <= plru_touch(plru_q[fill_idx], victim);
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge CLK) begin
        if (fill_c) begin
            tag_q[fill_idx][victim]  <= fill_tag;
            data_q[fill_idx][victim] <= bus.imem_load;
        end
    end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised successor to the direct-mapped instruction cache, with configurable set count, associativity and block size.
- Uses tree pseudo-LRU replacement and a latched-address fill FSM.
- Sits between fetch and the memory controller.
- Keeps the synchronous blocking core and mem handshakes (same-cycle hit, held request until imem_hit).

Parameters:
NUM_SETS, 8, sets; power of 2, >=2
NUM_WAYS, 2, ways per set; power of 2, 1..8
BLOCK_WORDS, 2, 32-bit words per block; power of 2, >=2

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
DUT_error  out  1  protocol violation, 1-cycle pulse
icache_REN  in  1  fetch request
icache_addr  in  32  byte address (word_t)
icache_halt  in  1  core halted; suppress service
icache_hit  out  1  load valid this cycle
icache_load  out  32  instruction word
imem_REN  out  1  block fill request
imem_block_addr  out  30-log2(BLOCK_WORDS)  block address = addr >> (2+log2(BLOCK_WORDS))
imem_hit  in  1  fill data valid
imem_load  in  32*BLOCK_WORDS  block; word i at bits [32i+31:32i]

Behaviour:
- One clock (CLK). RST is synchronous and active-high.
- Address split: [1:0] byte offset (ignored); next log2(BLOCK_WORDS) bits select the word; next log2(NUM_SETS) bits are the index; remainder is the tag.
- Reset: all valid bits cleared, PLRU bits 0, FSM = IDLE. All outputs read 0 in the reset cycle and the following cycle.
- icache_hit is combinational:
  - Asserted when REN && !halt && FSM != HALTED && tag matches a valid way in the indexed set.
  - icache_load = selected word when hit, else 32'h0.
- PLRU updates at the clock edge on every hit and on every fill, pointing away from the accessed way.
- FSM states: IDLE, FILL, HALTED.
- IDLE:
  - On REN && !halt && miss, the block address is driven combinationally that cycle with imem_REN=1.
  - The block address is latched, and the next state is FILL.
- FILL:
  - imem_REN=1 and imem_block_addr = latched value, held stable.
  - Changes to icache_addr or icache_REN are ignored; the fill always completes.
  - icache_hit=0 throughout FILL.
  - On imem_hit: write data, tag and valid into the victim way; update PLRU; next state IDLE.
  - The refetch hits on the following cycle.
- Victim selection: lowest-indexed invalid way, else the PLRU way. NUM_WAYS=1 degenerates to direct-mapped.
- halt:
  - In IDLE, halt moves the FSM to HALTED.
  - In FILL, the fill completes first, then the FSM moves to HALTED.
  - HALTED is sticky until RST: imem_REN=0, icache_hit=0.
- DUT_error: 1-cycle pulse when imem_hit=1 while the FSM is not FILL (or not FILL/PREFETCH when the optional feature is compiled in). No other state change.
- Reset mid-fill: returns to IDLE, clears all valid bits, drops imem_REN in the reset cycle. The late imem_hit is flagged as DUT_error only if it arrives after reset deasserts.

Optional Feature:
- Macro: ICACHE_NEXT_LINE_PREFETCH_EN. Adds a PREFETCH state.
- With the macro: after a demand fill completes, if block+1 (wrapping modulo the address space) is not resident, the FSM enters PREFETCH and requests block+1.
  - Hits are serviced normally during PREFETCH.
  - A demand miss during PREFETCH stalls (hit=0) until the prefetch completes, then enters FILL.
  - halt during PREFETCH waits for completion, then enters HALTED.
- Without the macro: no PREFETCH state; IDLE follows every fill.

Test Plan (defaults NUM_SETS=8, NUM_WAYS=2, BLOCK_WORDS=2):
1. RST=1 for 2 cycles with random inputs -> icache_hit=0, icache_load=0, imem_REN=0, imem_block_addr=0, DUT_error=0.
2. Cold miss:
   - REN=1, addr=0x40 -> same cycle imem_REN=1, block_addr=0x08.
   - Next cycle imem_hit=1, imem_load={0xBBBB0002,0xAAAA0001} -> following cycle hit=1, load=0xAAAA0001.
   - addr=0x44 -> hit=1, load=0xBBBB0002, imem_REN=0.
3. PLRU:
   - Fill 0x40 then 0x80 (both set 0), read 0x40, then miss 0x100 -> fill at block_addr 0x20 replaces the 0x80 way.
   - After the fill, 0x40 hits and 0x80 misses (block_addr 0x10).
4. imem_hit=1 in IDLE -> DUT_error=1 for exactly one cycle; a later 0x40 access still hits.
5. RST asserted during FILL of 0x40 -> imem_REN=0 next cycle; after RST drops, 0x40 misses again (block_addr 0x08).
6. halt=1 during FILL -> fill completes, then hit=0 and imem_REN=0 for all later REN=1 cycles. With ICACHE_NEXT_LINE_PREFETCH_EN, the 0x40 fill is followed by imem_REN=1, block_addr=0x09.
